// File: rtl/pfd_loop_ctrl.sv
// pfd_loop_ctrl: ring-osc PLL loop controller; windows PFD up/down, coarse/fine code search.
// Ports: clk, temp_reset_out (async, active-low), enable, up, down -> tune_code, state, locked, sat.
// Define PFD_LOCK_DETECT_EN to build the LOCKED state, bal_cnt and the locked output.
module pfd_loop_ctrl #(
  parameter int CODE_W      = 8,
  parameter int CODE_INIT   = 128,
  parameter int COARSE_STEP = 8,
  parameter int WIN_W       = 6,
  parameter int DEADBAND    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic              clk,
  input  logic              temp_reset_out,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  output logic [CODE_W-1:0] tune_code,
  output logic [1:0]        state,
  output logic              locked,
  output logic              sat
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_COARSE = 2'b01;
  localparam logic [1:0] S_FINE   = 2'b10;
`ifdef PFD_LOCK_DETECT_EN
  localparam logic [1:0] S_LOCKED = 2'b11;
  localparam int BAL_W =
    ($clog2(LOCK_CNT) > 0) ? $clog2(LOCK_CNT) : 1;
  localparam logic [BAL_W-1:0] BAL_LAST =
    BAL_W'(LOCK_CNT - 1);
`endif

  localparam int DW = WIN_W + 2;
  localparam logic signed [DW-1:0] DB_P = DW'(DEADBAND);
  localparam logic signed [DW-1:0] DB_N = DW'(-DEADBAND);
  localparam logic [CODE_W:0] STEP_C = (CODE_W+1)'(COARSE_STEP);
  localparam logic [CODE_W:0] STEP_F = (CODE_W+1)'(1);
  localparam logic [CODE_W-1:0] INIT = CODE_W'(CODE_INIT);

  logic              up_s1, up_s2;
  logic              dn_s1, dn_s2;
  logic [WIN_W-1:0]  wcnt;
  logic [WIN_W:0]    up_cnt, dn_cnt;
  logic [WIN_W:0]    win_up, win_dn;
  logic signed [DW-1:0] diff;
  logic              run, win_end;
  logic              dec_vld, dec_up, dec_dn, dec_nz;
  logic              prev_up, prev_dn, flip;
  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              sat_q, sat_d;
  logic              pu_d, pd_d;
  logic [CODE_W:0]   step, code_x, sum_up, sum_dn;
  logic [CODE_W-1:0] st_code;
  logic              st_sat;
`ifdef PFD_LOCK_DETECT_EN
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic              locked_q;
`endif

  // PFD pulses are asynchronous: two-flop synchronizers
  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      up_s1 <= 1'b0;
      up_s2 <= 1'b0;
      dn_s1 <= 1'b0;
      dn_s2 <= 1'b0;
    end else begin
      up_s1 <= up;
      up_s2 <= up_s1;
      dn_s1 <= down;
      dn_s2 <= dn_s1;
    end
  end

  assign run     = enable && (state_q != S_IDLE);
  assign win_end = run && (wcnt == '1);

  // Window totals include the sample of the wrap cycle itself
  assign win_up = up_cnt + {{WIN_W{1'b0}}, up_s2};
  assign win_dn = dn_cnt + {{WIN_W{1'b0}}, dn_s2};
  assign diff   = $signed({1'b0, win_up}) - $signed({1'b0, win_dn});

  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      wcnt   <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
    end else if (!run || win_end) begin
      wcnt   <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      wcnt   <= wcnt + 1'b1;
      up_cnt <= win_up;
      dn_cnt <= win_dn;
    end
  end

  // Decision is registered; code/state act on it one cycle later
  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      dec_vld <= 1'b0;
      dec_up  <= 1'b0;
      dec_dn  <= 1'b0;
    end else begin
      dec_vld <= win_end;
      dec_up  <= win_end && (diff > DB_P);
      dec_dn  <= win_end && (diff < DB_N);
    end
  end

  assign dec_nz = dec_up || dec_dn;
  assign flip   = (dec_up && prev_dn) || (dec_dn && prev_up);

  // Saturating step of the tuning code
  assign step   = (state_q == S_COARSE) ? STEP_C : STEP_F;
  assign code_x = {1'b0, code_q};
  assign sum_up = code_x + step;
  assign sum_dn = code_x - step;

  always_comb begin
    st_code = code_q;
    st_sat  = 1'b0;
    unique case (1'b1)
      dec_up: begin
        if (sum_up[CODE_W]) begin
          st_code = '1;
          st_sat  = 1'b1;
        end else begin
          st_code = sum_up[CODE_W-1:0];
        end
      end
      dec_dn: begin
        if (step > code_x) begin
          st_code = '0;
          st_sat  = 1'b1;
        end else begin
          st_code = sum_dn[CODE_W-1:0];
        end
      end
      default: begin
        st_code = code_q;
        st_sat  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_COARSE;
      end
      S_COARSE: begin
        if (dec_vld && (!dec_nz || flip))
          state_d = S_FINE;
      end
      S_FINE: begin
`ifdef PFD_LOCK_DETECT_EN
        if (dec_vld && !dec_nz && bal_q == BAL_LAST)
          state_d = S_LOCKED;
`endif
      end
      default: begin
`ifdef PFD_LOCK_DETECT_EN
        if (dec_vld && dec_nz) state_d = S_FINE;
`else
        state_d = S_FINE;
`endif
      end
    endcase
    if (!enable) state_d = S_IDLE;
  end

  always_comb begin
    code_d = code_q;
    sat_d  = sat_q;
    pu_d   = prev_up;
    pd_d   = prev_dn;
`ifdef PFD_LOCK_DETECT_EN
    bal_d  = bal_q;
`endif
    if (enable) begin
      if (state_q == S_IDLE) begin
        code_d = INIT;
        sat_d  = 1'b0;
        pu_d   = 1'b0;
        pd_d   = 1'b0;
`ifdef PFD_LOCK_DETECT_EN
        bal_d  = '0;
`endif
      end else if (dec_vld) begin
        if (dec_nz) begin
          code_d = st_code;
          sat_d  = sat_q | st_sat;
        end
        if (state_q == S_COARSE && dec_nz) begin
          pu_d = dec_up;
          pd_d = dec_dn;
        end
`ifdef PFD_LOCK_DETECT_EN
        if (state_q == S_FINE && !dec_nz)
          bal_d = (bal_q == BAL_LAST) ? '0 : bal_q + 1'b1;
        else
          bal_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      code_q  <= INIT;
      sat_q   <= 1'b0;
      prev_up <= 1'b0;
      prev_dn <= 1'b0;
    end else begin
      code_q  <= code_d;
      sat_q   <= sat_d;
      prev_up <= pu_d;
      prev_dn <= pd_d;
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  always_ff @(posedge clk or negedge temp_reset_out) begin
    if (!temp_reset_out) begin
      bal_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      bal_q    <= bal_d;
      locked_q <= (state_d == S_LOCKED);
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign tune_code = code_q;
  assign state     = state_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_pfd_loop_ctrl.sv
// tb_pfd_loop_ctrl: directed bench for pfd_loop_ctrl.
// Second instance uses CODE_INIT=250 for the clamp case.
module tb_pfd_loop_ctrl;

  logic       clk = 1'b0;
  logic       temp_reset_out = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [7:0] code_a, code_b;
  logic [1:0] state_a, state_b;
  logic       locked_a, locked_b;
  logic       sat_a, sat_b;

  int checks = 0;
  int failures = 0;
  int t = 0;

`ifdef PFD_LOCK_DETECT_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  pfd_loop_ctrl dut (
    .clk(clk), .temp_reset_out(temp_reset_out),
    .enable(enable), .up(up), .down(down),
    .tune_code(code_a), .state(state_a),
    .locked(locked_a), .sat(sat_a)
  );

  pfd_loop_ctrl #(.CODE_INIT(250)) dut_hi (
    .clk(clk), .temp_reset_out(temp_reset_out),
    .enable(enable), .up(up), .down(down),
    .tune_code(code_b), .state(state_b),
    .locked(locked_b), .sat(sat_b)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic u, input logic d);
    temp_reset_out = 1'b0;
    enable = 1'b0;
    up = u;
    down = d;
    repeat (2) @(posedge clk);
    #2 temp_reset_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Edge index 0 is the edge that moves IDLE -> COARSE
  task automatic start();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
  endtask

  task automatic goto(input int k);
    while (t < k) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    temp_reset_out = 1'b0;
    enable = 1'b1;
    up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_a !== 2'b00) begin
      $display("FAIL rst_state got=%0d exp=0", state_a);
      failures++;
    end
    checks++;
    if (code_a !== 8'd128) begin
      $display("FAIL rst_code got=%0d exp=128", code_a);
      failures++;
    end
    checks++;
    if (locked_a !== 1'b0 || sat_a !== 1'b0) begin
      $display("FAIL rst_flags got=%b%b exp=00", locked_a, sat_a);
      failures++;
    end
    checks++;
    if (code_b !== 8'd250) begin
      $display("FAIL rst_code_hi got=%0d exp=250", code_b);
      failures++;
    end
  endtask

  task automatic test_balanced();
    do_reset(1'b0, 1'b0);
    start();
    goto(32);
    checks++;
    if (state_a !== 2'b01) begin
      $display("FAIL bal_coarse got=%0d exp=1", state_a);
      failures++;
    end
    goto(96);
    checks++;
    if (state_a !== 2'b10 || code_a !== 8'd128 || sat_a !== 1'b0) begin
      $display("FAIL bal_fine got=s%0d c%0d sat%0d exp=s2 c128 sat0",
               state_a, code_a, sat_a);
      failures++;
    end
  endtask

  task automatic test_coarse_up_flip();
    do_reset(1'b1, 1'b0);
    start();
    goto(96);
    checks++;
    if (code_a !== 8'd136 || state_a !== 2'b01) begin
      $display("FAIL up_w1 got=c%0d s%0d exp=c136 s1", code_a, state_a);
      failures++;
    end
    goto(160);
    checks++;
    if (code_a !== 8'd144) begin
      $display("FAIL up_w2 got=%0d exp=144", code_a);
      failures++;
    end
    goto(192);
    up = 1'b0;
    down = 1'b1;
    goto(224);
    checks++;
    if (code_a !== 8'd152 || state_a !== 2'b01) begin
      $display("FAIL up_w3 got=c%0d s%0d exp=c152 s1", code_a, state_a);
      failures++;
    end
    goto(288);
    checks++;
    if (code_a !== 8'd144 || state_a !== 2'b10) begin
      $display("FAIL flip got=c%0d s%0d exp=c144 s2", code_a, state_a);
      failures++;
    end
    goto(352);
    checks++;
    if (code_a !== 8'd143 || state_a !== 2'b10) begin
      $display("FAIL fine_dn got=c%0d s%0d exp=c143 s2", code_a, state_a);
      failures++;
    end
  endtask

  task automatic test_coarse_down();
    do_reset(1'b0, 1'b1);
    start();
    goto(96);
    checks++;
    if (code_a !== 8'd120) begin
      $display("FAIL dn_w1 got=%0d exp=120", code_a);
      failures++;
    end
    goto(160);
    checks++;
    if (code_a !== 8'd112 || state_a !== 2'b01) begin
      $display("FAIL dn_w2 got=c%0d s%0d exp=c112 s1", code_a, state_a);
      failures++;
    end
  endtask

  task automatic test_lock();
    do_reset(1'b0, 1'b0);
    start();
    goto(1056);
    checks++;
    if (state_a !== 2'b10 || locked_a !== 1'b0) begin
      $display("FAIL prelock got=s%0d l%0d exp=s2 l0", state_a, locked_a);
      failures++;
    end
    goto(1120);
    checks++;
    if (state_a !== (LK ? 2'b11 : 2'b10) || locked_a !== LK
        || code_a !== 8'd128) begin
      $display("FAIL lock got=s%0d l%0d c%0d exp=s%0d l%0d c128",
               state_a, locked_a, code_a, LK ? 3 : 2, LK);
      failures++;
    end
    goto(1152);
    up = 1'b1;
    goto(1216);
    checks++;
    if (locked_a !== LK || code_a !== 8'd128) begin
      $display("FAIL lock_hold got=l%0d c%0d exp=l%0d c128",
               locked_a, code_a, LK);
      failures++;
    end
    goto(1217);
    checks++;
    if (state_a !== 2'b10 || locked_a !== 1'b0 || code_a !== 8'd129) begin
      $display("FAIL unlock got=s%0d l%0d c%0d exp=s2 l0 c129",
               state_a, locked_a, code_a);
      failures++;
    end
  endtask

  task automatic test_sat();
    do_reset(1'b1, 1'b0);
    start();
    goto(32);
    checks++;
    if (code_b !== 8'd250 || sat_b !== 1'b0) begin
      $display("FAIL sat_pre got=c%0d sat%0d exp=c250 sat0", code_b, sat_b);
      failures++;
    end
    goto(96);
    checks++;
    if (code_b !== 8'd255 || sat_b !== 1'b1 || state_b !== 2'b01) begin
      $display("FAIL sat_clamp got=c%0d sat%0d s%0d exp=c255 sat1 s1",
               code_b, sat_b, state_b);
      failures++;
    end
    goto(160);
    enable = 1'b0;
    goto(161);
    checks++;
    if (state_b !== 2'b00 || code_b !== 8'd255 || sat_b !== 1'b1) begin
      $display("FAIL sat_idle got=s%0d c%0d sat%0d exp=s0 c255 sat1",
               state_b, code_b, sat_b);
      failures++;
    end
    checks++;
    if (state_a !== 2'b00 || code_a !== 8'd144 || locked_a !== 1'b0) begin
      $display("FAIL idle_hold got=s%0d c%0d l%0d exp=s0 c144 l0",
               state_a, code_a, locked_a);
      failures++;
    end
    goto(170);
    start();
    checks++;
    if (state_b !== 2'b01 || code_b !== 8'd250 || sat_b !== 1'b0) begin
      $display("FAIL reenter got=s%0d c%0d sat%0d exp=s1 c250 sat0",
               state_b, code_b, sat_b);
      failures++;
    end
    goto(40);
    enable = 1'b0;
    goto(100);
    checks++;
    if (state_a !== 2'b00 || code_a !== 8'd128) begin
      $display("FAIL discard got=s%0d c%0d exp=s0 c128", state_a, code_a);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0);
    start();
    goto(100);
    checks++;
    if (code_a !== 8'd136 || sat_b !== 1'b1) begin
      $display("FAIL pre_arst got=c%0d sat%0d exp=c136 sat1", code_a, sat_b);
      failures++;
    end
    #2 temp_reset_out = 1'b0;
    #1;
    checks++;
    if (state_a !== 2'b00 || code_a !== 8'd128 || sat_a !== 1'b0
        || locked_a !== 1'b0) begin
      $display("FAIL arst_a got=s%0d c%0d sat%0d l%0d exp=s0 c128 sat0 l0",
               state_a, code_a, sat_a, locked_a);
      failures++;
    end
    checks++;
    if (code_b !== 8'd250 || sat_b !== 1'b0 || state_b !== 2'b00) begin
      $display("FAIL arst_b got=c%0d sat%0d s%0d exp=c250 sat0 s0",
               code_b, sat_b, state_b);
      failures++;
    end
    @(negedge clk);
    temp_reset_out = 1'b1;
  endtask

  initial begin
    test_reset();
    test_balanced();
    test_coarse_up_flip();
    test_coarse_down();
    test_lock();
    test_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
